// File: rtl/clk_step_ctrl.sv
// rtl/clk_step_ctrl.sv - divided/stepped CPU clock generator with debounced step key and glitch-free tap/mode switching
// Optional breakpoint halt enabled by defining CLK_STEP_BREAKPOINT_EN.
module clk_step_ctrl #(
    parameter int CNT_W       = 32,
    parameter int SEL_W       = 16,
    parameter int TAP_FAST    = 1,
    parameter int TAP_LO      = 14,
    parameter int DEFAULT_TAP = 25,
    parameter int DB_CNT      = 1000000,
    parameter int STEP_HI     = 4,
    parameter int LED_W       = 3,
    parameter int LED_SHIFT   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sw,
    input  logic             key_step,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      bp_addr,
    output logic             clk_out,
    output logic             clk_en,
    output logic             bp_hit,
    output logic [LED_W-1:0] LED_clk
);

    localparam int TW  = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int DBW = $clog2(DB_CNT + 1);
    localparam int HW  = (STEP_HI > 1) ? $clog2(STEP_HI + 1) : 1;
    localparam logic [TW-1:0] DEF_TAP = TW'(DEFAULT_TAP);

`ifdef CLK_STEP_BREAKPOINT_EN
    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_STEP_IDLE = 3'd1,
        ST_STEP_HI   = 3'd2,
        ST_HALT      = 3'd3,
        ST_BP_HALT   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_STEP_IDLE = 3'd1,
        ST_STEP_HI   = 3'd2,
        ST_HALT      = 3'd3
    } state_t;
`endif

    state_t            state, state_next, mode_state;
    logic [CNT_W-1:0]  count;
    logic [TW-1:0]     tap_active, req_tap;
    logic              key_s1, key_s2, db_key, db_prev, press;
    logic [DBW-1:0]    db_cnt;
    logic [HW-1:0]     hi_cnt;
    logic [LED_W-1:0]  step_cnt, led_run;
    logic              armed, clk_next, step_inc;

    function automatic logic [TW-1:0] clamp_tap(input int t);
        return (t >= CNT_W) ? TW'(CNT_W - 1) : TW'(t);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count + CNT_W'(1);
    end

    // Lowest set select bit wins, so it is applied last.
    always_comb begin
        req_tap = DEF_TAP;
        for (int k = SEL_W - 1; k >= 5; k--) begin
            if (sw[k]) req_tap = clamp_tap(TAP_LO + k - 5);
        end
        if (SEL_W > 4 && sw[4]) req_tap = clamp_tap(TAP_FAST);
    end

    // Both old and new taps must be low so the output cannot glitch across the swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tap_active <= DEF_TAP;
        else if (!clk_out && !count[tap_active] && !count[req_tap])
            tap_active <= req_tap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
        end else begin
            key_s1 <= key_step;
            key_s2 <= key_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_key  <= 1'b0;
            db_prev <= 1'b0;
            db_cnt  <= '0;
        end else begin
            db_prev <= db_key;
            if (key_s2 == db_key) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DB_CNT - 1)) begin
                db_key <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

    assign press      = db_key & ~db_prev;
    assign mode_state = sw[1] ? ST_HALT : (sw[0] ? ST_STEP_IDLE : ST_RUN);

`ifdef CLK_STEP_BREAKPOINT_EN
    logic bp_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bp_pend <= 1'b0;
        else     bp_pend <= (state == ST_RUN) && (bp_pend || (clk_en && sw[2] && (pc_in == bp_addr)));
    end
`endif

    always_comb begin
        state_next = state;
        clk_next   = 1'b0;
        step_inc   = 1'b0;
        case (state)
            ST_RUN: begin
                // Only a full rising phase may start a pulse after entering RUN.
                clk_next = count[tap_active] & (clk_out | armed);
                if (!clk_out) begin
`ifdef CLK_STEP_BREAKPOINT_EN
                    if (bp_pend) begin
                        state_next = ST_BP_HALT;
                        clk_next   = 1'b0;
                    end else
`endif
                    if (mode_state != ST_RUN) begin
                        state_next = mode_state;
                        clk_next   = 1'b0;
                    end
                end
            end
            ST_STEP_IDLE: begin
                if (press) begin
                    state_next = ST_STEP_HI;
                    clk_next   = 1'b1;
                    step_inc   = 1'b1;
                end else if (mode_state != ST_STEP_IDLE) begin
                    state_next = mode_state;
                end
            end
            ST_STEP_HI: begin
                clk_next = 1'b1;
                if (hi_cnt == HW'(STEP_HI - 1)) begin
                    state_next = mode_state;
                    clk_next   = 1'b0;
                end
            end
            ST_HALT: begin
                if (mode_state != ST_HALT) state_next = mode_state;
            end
`ifdef CLK_STEP_BREAKPOINT_EN
            ST_BP_HALT: begin
                if (press) begin
                    state_next = ST_STEP_HI;
                    clk_next   = 1'b1;
                    step_inc   = 1'b1;
                end else if (mode_state != ST_RUN) begin
                    state_next = mode_state;
                end
            end
`endif
            default: state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_HALT;
            clk_out  <= 1'b0;
            clk_en   <= 1'b0;
            step_cnt <= '0;
            hi_cnt   <= '0;
            armed    <= 1'b0;
        end else begin
            state   <= state_next;
            clk_out <= clk_next;
            clk_en  <= clk_next & ~clk_out;
            if (step_inc) step_cnt <= step_cnt + LED_W'(1);
            if (state == ST_STEP_HI) hi_cnt <= hi_cnt + HW'(1);
            else                     hi_cnt <= '0;
            armed <= (state == ST_RUN) && (armed || !count[tap_active]);
        end
    end

`ifdef CLK_STEP_BREAKPOINT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bp_hit <= 1'b0;
        else     bp_hit <= (state_next == ST_BP_HALT);
    end

    logic unused_in;
    assign unused_in = sw[3];
`else
    assign bp_hit = 1'b0;

    logic unused_in;
    assign unused_in = ^{sw[3:2], pc_in, bp_addr};
`endif

    // Heartbeat bits beyond the counter width read as zero.
    for (genvar i = 0; i < LED_W; i++) begin : g_led
        if (LED_SHIFT + i < CNT_W) begin : g_in
            assign led_run[i] = count[LED_SHIFT + i];
        end else begin : g_out
            assign led_run[i] = 1'b0;
        end
    end

    assign LED_clk = (state == ST_RUN) ? led_run : step_cnt;

endmodule

// File: doc/clk_step_ctrl.md
Name: clk_step_ctrl

Overview:
- Programmable CPU clock generator for the pipelined core on the FPGA board.
- Derives a slow divided clock (clk_out) plus a one-cycle rising-edge enable (clk_en) from the board clock.
- Modes: free-run with switch-selected divide tap, debounced single-step from a key, or halt.
- Tap and mode switching are glitch-free. LEDs show a heartbeat or a step count.

Parameters:
- CNT_W, 32, width of the free-running divider counter
- SEL_W, 16, width of sw
- TAP_FAST, 1, tap used when sw[4] is set
- TAP_LO, 14, tap for sw[5]; sw[k] (k≥5) maps to TAP_LO+(k-5)
- DEFAULT_TAP, 25, tap when no sw[SEL_W-1:4] bit is set; must be < CNT_W
- DB_CNT, 1000000, cycles key must be stable to be accepted
- STEP_HI, 4, clk_out high cycles per single step
- LED_W, 3, LED width
- LED_SHIFT, 10, heartbeat LED slice LSB in count

Ports:
- clk  in  1  board clock
- rst  in  1  reset
- sw  in  SEL_W  sw[1:0] mode, sw[2] breakpoint enable, sw[SEL_W-1:4] tap select
- key_step  in  1  raw step/resume key, asynchronous
- pc_in  in  32  current PC
- bp_addr  in  32  breakpoint address
- clk_out  out  1  divided CPU clock
- clk_en  out  1  one-cycle pulse in the cycle clk_out rises
- bp_hit  out  1  breakpoint halt indicator
- LED_clk  out  LED_W  status LEDs

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: count=0, clk_out=0, clk_en=0, bp_hit=0, step_cnt=0, state=HALT, tap_active=DEFAULT_TAP, debouncer cleared.
- Counter: count increments every cycle and wraps modulo 2^CNT_W.
- Tap request: the lowest set bit in sw[SEL_W-1:4] wins. sw[4] selects TAP_FAST; none set selects DEFAULT_TAP.
- Tap switch: tap_active loads the requested tap only in a cycle where clk_out==0 and count[requested]==0. No runt pulses.
- Key path: 2-FF synchroniser feeds the debouncer. db_key changes only after DB_CNT consecutive equal samples. press = 0→1 edge of db_key, one cycle wide.
- States: RUN, STEP_IDLE, STEP_HI, HALT, BP_HALT.
- Mode decode: sw[1:0]=00 RUN; 01 STEP_IDLE; 1x HALT.
- RUN: clk_out <= count[tap_active].
  - Leaves RUN for the new mode only when clk_out==0. A high phase is never truncated.
- STEP_IDLE: clk_out=0.
  - press → STEP_HI, clk_out=1 next cycle, clk_en pulses, step_cnt++.
- STEP_HI: holds clk_out=1 for exactly STEP_HI cycles, then returns to the decoded mode with clk_out=0.
  - Presses during STEP_HI are ignored.
- HALT: clk_out=0, clk_en=0. Exits to the decoded mode on the next cycle after sw[1:0] changes.
- clk_en: registered. High exactly one cycle, coincident with the first high cycle of clk_out. Never high in HALT/BP_HALT.
- LED_clk:
  - In RUN, count[LED_SHIFT+LED_W-1:LED_SHIFT].
  - Otherwise, step_cnt[LED_W-1:0]. step_cnt wraps.
- Reset mid-operation: all outputs forced to reset values immediately (asynchronous). No partial step completes.

Optional Feature:
- Macro: CLK_STEP_BREAKPOINT_EN.
- Defined: in RUN with sw[2]=1, the cycle clk_en pulses with pc_in==bp_addr → BP_HALT after the current high phase ends.
  - In BP_HALT, clk_out=0 and bp_hit=1.
  - A press → STEP_HI (one step, bp_hit cleared), then returns to the decoded mode.
  - A mode change to non-RUN leaves BP_HALT with bp_hit cleared.
- Undefined: no comparator or BP_HALT state. bp_hit tied 0. pc_in, bp_addr and sw[2] ignored.

Test Plan (CNT_W=8, DB_CNT=4, DEFAULT_TAP=6, TAP_LO=3, STEP_HI=4):
- Reset, sw=0 → clk_out period 128 cycles, 50% duty. clk_en one pulse per period, on the cycle clk_out rises. LED_clk tracks count[12:10] slice (count[10+] unused, width clamp checked).
- sw[5]=1 mid-high-phase → current high phase completes at tap 6, then period 16. No clk_out pulse shorter than 8 cycles.
- sw[1:0]=01, key bounces 1-0-1 within 3 cycles, then held high 10 cycles → exactly one 4-cycle clk_out pulse, one clk_en, LED_clk=1.
- sw[1:0]=10 during high phase → clk_out falls at the natural edge, then stays 0. clk_en stays 0 for 500 cycles.
- Macro on, sw[2]=1, bp_addr=0x40, pc_in=0x40 at clk_en → bp_hit=1, clk_out low. Press → one 4-cycle step, bp_hit=0.
- rst asserted during STEP_HI → clk_out=0, clk_en=0, LED_clk=0 the same cycle. State HALT after release.
